imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
- Parametrised, pipelined successor to the combinational immediate generator in the decode path.
- Accepts one instruction plus PC per valid/ready handshake and decodes the immediate format from the opcode.
- Emits one sign-extended XLEN immediate, the PC-relative target and a target-misalignment flag.
- Sits between fetch and the register-read/execute stage. A two-entry skid buffer gives full throughput with a registered in_ready.

Parameters:
- XLEN, 32: datapath width; 32 or 64; immediates sign-extend to XLEN.
- IALIGN, 32: instruction alignment; 32 (no C extension) or 16.
- RV64_OPS, 0: when 1, opcodes 0011011 (OP-IMM-32) and 0111011 (OP-32) decode as I and R formats.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  discard all buffered entries (branch redirect).
- in_valid  in  1  upstream has an instruction.
- in_ready  out  1  block can accept; registered.
- in_instr  in  32  raw instruction word.
- in_pc  in  XLEN  PC of in_instr.
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream accepts.
- out_fmt  out  3  format enum: R=0, I=1, S=2, B=3, U=4, J=5, ILLEGAL=7.
- out_imm  out  XLEN  selected immediate.
- out_target  out  XLEN  PC-relative result.
- out_misaligned  out  1  out_target violates IALIGN (B/J only).
- out_pc  out  XLEN  PC passed through.

Behaviour:
- rst is sampled only on clk edges. Reset clears both entry valids. out_valid=0 and in_ready=1 from the first cycle after reset. All data outputs are 0 after reset.
- Format decode on instr[6:0]:
  - I: 0000011, 0010011, 1100111, 0001111, 1110011.
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
  - R: 0110011.
  - RV64_OPS=1 adds the two RV64 opcodes listed under Parameters.
  - Any other opcode is ILLEGAL, with imm=0, target=0 and misaligned=0.
- Immediate bit-assembly follows the RV spec for I/S/B/U/J. Sign bit is instr[31], extended to XLEN. U-type on XLEN=64 also sign-extends from bit 31.
- out_target:
  - pc+imm for B, J and AUIPC (0010111); arithmetic modulo 2^XLEN, wrap allowed and not flagged.
  - 0 for all other formats and opcodes. JALR target needs rs1 and is not computed here.
- out_misaligned = target[0] | (IALIGN==32 & target[1]), for B/J only.
- Decode and add happen in the input cycle. Results register into the main entry, so latency is 1 cycle (accept at edge N, out_valid at N+1).
- Handshake:
  - Transfer occurs when valid & ready are both high at an edge.
  - out_* hold stable while out_valid & !out_ready.
  - in_ready = !skid_valid.
  - If the main entry is occupied and not draining when an accept happens, the new entry goes to skid. When main drains, skid moves to main.
  - Order is strictly preserved. Same-cycle accept and drain with skid empty yields no bubble.
- flush has priority over accept: both entries are invalidated at the edge and the input beat in that cycle is dropped. in_ready=1 on the next cycle.
- rst mid-transfer: entries are discarded the same way as flush.

Decomposition:
- Package imm_pkg holds:
  - the fmt_e enum;
  - opcode localparams;
  - a pure function decode_imm(instr) returning fmt and imm at XLEN.
- One sub-module, imm_skid_buf, implements the generic 2-entry valid/ready skid buffer parametrised by payload width.
- Top level does decode, add and misalignment, then packs the payload.

Test Plan:
- Decode/extend: 0xFFF00093 (addi x1,x0,-1), pc 0x0 -> one cycle later fmt=I, imm=0xFFFFFFFF, target=0.
- B-type target: 0xFE000EE3 (beq x0,x0,-4), pc 0x100 -> fmt=B, imm=0xFFFFFFFC, target=0xFC, misaligned=0.
- J-type misalignment: 0x0020006F (jal x0,+2), pc 0x200.
  - IALIGN=32 -> target=0x202, misaligned=1.
  - IALIGN=16 -> misaligned=0.
- U-type, XLEN=64: 0x800000B7 (lui x1,0x80000) -> imm=0xFFFFFFFF80000000.
- Backpressure: hold out_ready=0 and send A then B on consecutive cycles.
  - in_ready drops after B.
  - Release out_ready: A then B emerge in order on consecutive cycles.
- Flush/reset: with 2 entries buffered, assert flush together with in_valid.
  - Next cycle: out_valid=0, in_ready=1, no entry lost beyond those flushed.
  - Repeat the scenario using rst; same result.

Source files
------------

// File: rtl/imm_pkg.sv
// imm_pkg: shared format enum, opcodes and immediate decode for the imm_gen pipeline
package imm_pkg;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd7
    } fmt_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_32     = 7'b0111011;

    // imm is produced at the widest XLEN; narrower datapaths truncate it
    typedef struct packed {
        fmt_e        fmt;
        logic [63:0] imm;
    } dec_t;

    function automatic dec_t decode_imm(input logic [31:0] instr, input logic rv64);
        dec_t d;
        d.fmt = FMT_ILL;
        d.imm = '0;
        case (instr[6:0])
            OP_LOAD, OP_IMM, OP_JALR, OP_FENCE, OP_SYSTEM: d.fmt = FMT_I;
            OP_STORE:         d.fmt = FMT_S;
            OP_BRANCH:        d.fmt = FMT_B;
            OP_LUI, OP_AUIPC: d.fmt = FMT_U;
            OP_JAL:           d.fmt = FMT_J;
            OP_OP:            d.fmt = FMT_R;
            OP_IMM32:         d.fmt = rv64 ? FMT_I : FMT_ILL;
            OP_32:            d.fmt = rv64 ? FMT_R : FMT_ILL;
            default:          d.fmt = FMT_ILL;
        endcase
        case (d.fmt)
            FMT_I:   d.imm = {{52{instr[31]}}, instr[31:20]};
            FMT_S:   d.imm = {{52{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   d.imm = {{52{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U:   d.imm = {{32{instr[31]}}, instr[31:12], 12'b0};
            FMT_J:   d.imm = {{44{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            default: d.imm = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/imm_skid_buf.sv
// imm_skid_buf: two-entry valid/ready skid buffer with registered in_ready
module imm_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    logic         skid_valid;
    logic [W-1:0] skid_data;
    logic         acc;
    logic         drain;

    assign in_ready = !skid_valid;
    assign acc      = in_valid && in_ready;
    assign drain    = out_valid && out_ready;

    // skid only fills while main is stalled, so acc and skid_valid never coincide
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            out_data   <= '0;
            skid_data  <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!out_valid || drain) begin
            out_valid <= skid_valid || acc;
            if (skid_valid) begin
                out_data   <= skid_data;
                skid_valid <= 1'b0;
            end else if (acc) begin
                out_data <= in_data;
            end
        end else if (acc) begin
            skid_valid <= 1'b1;
            skid_data  <= in_data;
        end
    end
endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: decodes immediate, PC-relative target and misalignment, buffered by a skid stage
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int IALIGN   = 32,
    parameter bit RV64_OPS = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2:0]      out_fmt,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_target,
    output logic            out_misaligned,
    output logic [XLEN-1:0] out_pc
);
    localparam int W = 4 + 3 * XLEN;

    dec_t            dec;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;
    logic            is_bj;
    logic            mis;
    logic [W-1:0]    in_data;
    logic [W-1:0]    out_data;

    assign dec    = decode_imm(in_instr, RV64_OPS);
    assign imm    = XLEN'(dec.imm);
    assign is_bj  = dec.fmt == FMT_B || dec.fmt == FMT_J;
    // JALR needs rs1, so only B, J and AUIPC produce a target here
    assign target = (is_bj || in_instr[6:0] == OP_AUIPC) ? in_pc + imm : '0;
    assign mis    = is_bj && (target[0] || (IALIGN == 32 && target[1]));
    assign in_data = {dec.fmt, mis, imm, target, in_pc};

    imm_skid_buf #(.W(W)) u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    assign {out_fmt, out_misaligned, out_imm, out_target, out_pc} = out_data;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed plus randomized checks of three imm_gen_pipe configurations against a queue model
module tb_imm_gen_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] instr = '0;
    logic [63:0] pc = '0;

    logic        a_v, a_r, a_mis, b_v, b_r, b_mis, c_v, c_r, c_mis;
    logic [2:0]  a_f, b_f, c_f;
    logic [31:0] a_imm, a_tgt, a_pc, b_imm, b_tgt, b_pc;
    logic [63:0] c_imm, c_tgt, c_pc;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
    } item_t;
    item_t q[$];

    typedef struct {
        logic [2:0]  fmt;
        logic [63:0] imm;
        logic [63:0] tgt;
        logic        mis;
    } exp_t;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .IALIGN(32), .RV64_OPS(1'b0)) ua (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_r),
        .in_instr(instr), .in_pc(pc[31:0]), .out_valid(a_v), .out_ready(out_ready),
        .out_fmt(a_f), .out_imm(a_imm), .out_target(a_tgt), .out_misaligned(a_mis), .out_pc(a_pc));

    imm_gen_pipe #(.XLEN(32), .IALIGN(16), .RV64_OPS(1'b0)) ub (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_r),
        .in_instr(instr), .in_pc(pc[31:0]), .out_valid(b_v), .out_ready(out_ready),
        .out_fmt(b_f), .out_imm(b_imm), .out_target(b_tgt), .out_misaligned(b_mis), .out_pc(b_pc));

    imm_gen_pipe #(.XLEN(64), .IALIGN(32), .RV64_OPS(1'b1)) uc (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(c_r),
        .in_instr(instr), .in_pc(pc), .out_valid(c_v), .out_ready(out_ready),
        .out_fmt(c_f), .out_imm(c_imm), .out_target(c_tgt), .out_misaligned(c_mis), .out_pc(c_pc));

    function automatic exp_t ref_dec(input logic [31:0] ins, input logic [63:0] p,
                                     input int xlen, input int ialign, input bit rv64);
        exp_t e;
        logic [6:0] op;
        longint v;
        logic [63:0] m;
        op = ins[6:0];
        v = 0;
        m = (xlen == 64) ? '1 : 64'hFFFF_FFFF;
        e.fmt = 3'd7;
        if (op inside {7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111, 7'b1110011} ||
            (rv64 && op == 7'b0011011)) begin
            e.fmt = 3'd1;
            v = longint'($signed(ins[31:20]));
        end else if (op == 7'b0100011) begin
            e.fmt = 3'd2;
            v = longint'($signed({ins[31:25], ins[11:7]}));
        end else if (op == 7'b1100011) begin
            e.fmt = 3'd3;
            v = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
        end else if (op == 7'b0110111 || op == 7'b0010111) begin
            e.fmt = 3'd4;
            v = longint'($signed(ins[31:12])) * 4096;
        end else if (op == 7'b1101111) begin
            e.fmt = 3'd5;
            v = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
        end else if (op == 7'b0110011 || (rv64 && op == 7'b0111011)) begin
            e.fmt = 3'd0;
        end
        e.imm = 64'(v) & m;
        e.tgt = (e.fmt == 3'd3 || e.fmt == 3'd5 || op == 7'b0010111) ? ((p & m) + 64'(v)) & m : 64'd0;
        e.mis = (e.fmt == 3'd3 || e.fmt == 3'd5) && (e.tgt[0] || (ialign == 32 && e.tgt[1]));
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_dut(input string nm, input int xlen, input int ialign, input bit rv64,
                             input logic v, input logic r, input logic [2:0] f, input logic [63:0] imm,
                             input logic [63:0] tgt, input logic mis, input logic [63:0] p);
        exp_t e;
        logic [63:0] m;
        m = (xlen == 64) ? '1 : 64'hFFFF_FFFF;
        chk({nm, ".out_valid"}, 64'(v), 64'(q.size() > 0));
        chk({nm, ".in_ready"}, 64'(r), 64'(q.size() < 2));
        if (q.size() > 0) begin
            e = ref_dec(q[0].instr, q[0].pc, xlen, ialign, rv64);
            chk({nm, ".fmt"}, 64'(f), 64'(e.fmt));
            chk({nm, ".imm"}, imm, e.imm);
            chk({nm, ".target"}, tgt, e.tgt);
            chk({nm, ".misaligned"}, 64'(mis), 64'(e.mis));
            chk({nm, ".pc"}, p, q[0].pc & m);
        end
    endtask

    task automatic cycle();
        bit acc;
        bit drn;
        @(posedge clk);
        acc = in_valid && q.size() < 2;
        drn = q.size() > 0 && out_ready;
        if (rst || flush) q.delete();
        else begin
            if (drn) void'(q.pop_front());
            if (acc) q.push_back('{instr, pc});
        end
        @(negedge clk);
        check_dut("a", 32, 32, 1'b0, a_v, a_r, a_f, 64'(a_imm), 64'(a_tgt), a_mis, 64'(a_pc));
        check_dut("b", 32, 16, 1'b0, b_v, b_r, b_f, 64'(b_imm), 64'(b_tgt), b_mis, 64'(b_pc));
        check_dut("c", 64, 32, 1'b1, c_v, c_r, c_f, c_imm, c_tgt, c_mis, c_pc);
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [63:0] p,
                         input logic ordy, input logic fl, input logic rs);
        in_valid  = v;
        instr     = ins;
        pc        = p;
        out_ready = ordy;
        flush     = fl;
        rst       = rs;
        cycle();
    endtask

    logic [6:0] ops [15] = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111, 7'b1110011,
                             7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111,
                             7'b0110011, 7'b0011011, 7'b0111011, 7'b1101111, 7'b1100011};

    initial begin
        drive(1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 1'b1);
        chk("rst.fmt", 64'(a_f), 64'd0);
        chk("rst.imm", 64'(a_imm), 64'd0);
        chk("rst.target", c_tgt, 64'd0);
        chk("rst.pc", c_pc, 64'd0);
        chk("rst.mis", 64'(a_mis), 64'd0);

        drive(1'b1, 32'hFFF00093, 64'h0, 1'b1, 1'b0, 1'b0);
        chk("addi.fmt", 64'(a_f), 64'd1);
        chk("addi.imm", 64'(a_imm), 64'hFFFF_FFFF);
        chk("addi.target", 64'(a_tgt), 64'd0);

        drive(1'b1, 32'hFE000EE3, 64'h100, 1'b1, 1'b0, 1'b0);
        chk("beq.valid", 64'(a_v), 64'd1);
        chk("beq.fmt", 64'(a_f), 64'd3);
        chk("beq.imm", 64'(a_imm), 64'hFFFF_FFFC);
        chk("beq.target", 64'(a_tgt), 64'hFC);
        chk("beq.mis", 64'(a_mis), 64'd0);

        drive(1'b1, 32'h0020006F, 64'h200, 1'b1, 1'b0, 1'b0);
        chk("jal.target", 64'(a_tgt), 64'h202);
        chk("jal.mis32", 64'(a_mis), 64'd1);
        chk("jal.mis16", 64'(b_mis), 64'd0);

        drive(1'b1, 32'h800000B7, 64'h0, 1'b1, 1'b0, 1'b0);
        chk("lui.imm64", c_imm, 64'hFFFF_FFFF_8000_0000);
        chk("lui.imm32", 64'(a_imm), 64'h8000_0000);
        drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);

        drive(1'b1, 32'h00500093, 64'h300, 1'b0, 1'b0, 1'b0);
        chk("bp.ready_a", 64'(a_r), 64'd1);
        drive(1'b1, 32'h00A00113, 64'h304, 1'b0, 1'b0, 1'b0);
        chk("bp.ready_b", 64'(a_r), 64'd0);
        chk("bp.head_a", 64'(a_pc), 64'h300);
        drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);
        chk("bp.head_b", 64'(a_pc), 64'h304);
        chk("bp.valid_b", 64'(a_v), 64'd1);
        drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);
        chk("bp.empty", 64'(a_v), 64'd0);

        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 32'h00500093, 64'h400, 1'b0, 1'b0, 1'b0);
            drive(1'b1, 32'h00A00113, 64'h404, 1'b0, 1'b0, 1'b0);
            drive(1'b1, 32'h00F00193, 64'h408, 1'b0, k == 0, k == 1);
            chk("fl.valid", 64'(a_v), 64'd0);
            chk("fl.ready", 64'(a_r), 64'd1);
            drive(1'b1, 32'h0000006F, 64'h40C, 1'b1, 1'b0, 1'b0);
            chk("fl.next_pc", 64'(c_pc), 64'h40C);
            drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);
        end

        for (int n = 0; n < 400; n++) begin
            logic [31:0] ins;
            int idx;
            ins = $urandom;
            idx = $urandom_range(0, 15);
            if (idx < 15) ins[6:0] = ops[idx];
            drive($urandom_range(0, 3) != 0, ins, {$urandom, $urandom}, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 39) == 0, $urandom_range(0, 96) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
